// File: rtl/multi_contador.sv
// -----------------------------------------------------------------------------
// multi_contador
//
// Multi-channel stopwatch / countdown timer. NCH independent channels share a
// single prescaler that divides clk down to a one-second tick. Each channel
// counts up or down between 0 and a captured per-channel limit. There are four
// counting modes, run/hold control, a per-channel clear and a display freeze.
//
// Parameters
//   WIDTH     bits per channel value and limit
//   NCH       number of channels
//   TICK_DIV  clk cycles per tick (>= 2)
//
// Ports
//   clk     in   system clock
//   reseta  in   asynchronous active-low reset
//   cfg     in   1 = configuration mode; every channel is held in LOAD
//   mode    in   2 bits per channel: 00 up-stop, 01 down-stop,
//                10 down-reload, 11 up-wrap
//   tempo   in   per-channel limit/preset, channel i at [i*WIDTH +: WIDTH]
//   start   in   per-channel level: 1 = count, 0 = hold
//   clr     in   per-channel synchronous clear
//   pause   in   per-channel display freeze (counting continues)
//   aux     out  displayed value per channel
//   done    out  channel sits at its terminal value (modes 00/01)
//   tim     out  alarm square wave, toggles once per tick while done
//   wrap    out  one-cycle pulse after a reload/wrap (modes 10/11)
// -----------------------------------------------------------------------------
module multi_contador #(
    parameter int WIDTH    = 16,
    parameter int NCH      = 2,
    parameter int TICK_DIV = 25000000
) (
    input  logic                   clk,
    input  logic                   reseta,
    input  logic                   cfg,
    input  logic [2*NCH-1:0]       mode,
    input  logic [WIDTH*NCH-1:0]   tempo,
    input  logic [NCH-1:0]         start,
    input  logic [NCH-1:0]         clr,
    input  logic [NCH-1:0]         pause,
    output logic [WIDTH*NCH-1:0]   aux,
    output logic [NCH-1:0]         done,
    output logic [NCH-1:0]         tim,
    output logic [NCH-1:0]         wrap
);

    // -------------------------------------------------------------------------
    // Local types and constants
    // -------------------------------------------------------------------------
    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

    localparam logic [1:0] MODE_UP_STOP     = 2'b00;
    localparam logic [1:0] MODE_DOWN_STOP   = 2'b01;
    localparam logic [1:0] MODE_DOWN_RELOAD = 2'b10;
    localparam logic [1:0] MODE_UP_WRAP     = 2'b11;

    typedef enum logic [1:0] {
        ST_LOAD = 2'd0,
        ST_RUN  = 2'd1,
        ST_HOLD = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    // Up-counting modes start from 0, down-counting modes start from the limit.
    function automatic logic [WIDTH-1:0] init_value(input logic [1:0]       m,
                                                    input logic [WIDTH-1:0] t);
        return (m == MODE_UP_STOP || m == MODE_UP_WRAP) ? '0 : t;
    endfunction

    // State entered when leaving LOAD (or after a clear). In both stopping
    // modes a zero preset makes the initial value already terminal.
    function automatic state_e load_exit(input logic [1:0]       m,
                                         input logic [WIDTH-1:0] t,
                                         input logic             s);
        logic terminal;
        terminal = (t == '0) && (m == MODE_UP_STOP || m == MODE_DOWN_STOP);
        if (terminal)
            return ST_DONE;
        else if (s)
            return ST_RUN;
        else
            return ST_HOLD;
    endfunction

    // -------------------------------------------------------------------------
    // Shared prescaler
    // -------------------------------------------------------------------------
    logic [PW-1:0] presc_q, presc_d;
    logic          tick;

    // cfg holds the prescaler at 0 and also masks a tick that is pending in
    // the same cycle cfg rises.
    assign tick = !cfg && (presc_q == PRESC_LAST);

    always_comb begin
        if (cfg || tick)
            presc_d = '0;
        else
            presc_d = presc_q + PW'(1);
    end

    // NOTE: sequential state is written with non-blocking assignments only, so
    // every register samples the values that existed before the clock edge.
    always_ff @(posedge clk or negedge reseta) begin
        if (!reseta)
            presc_q <= '0;
        else
            presc_q <= presc_d;
    end

    // -------------------------------------------------------------------------
    // Per-channel counters
    // -------------------------------------------------------------------------
    for (genvar ch = 0; ch < NCH; ch++) begin : g_ch
        logic [1:0]       mode_c;
        logic [WIDTH-1:0] tempo_c;

        state_e           state_q, state_d;
        logic [WIDTH-1:0] value_q, value_d;
        logic [WIDTH-1:0] limit_q, limit_d;
        logic [WIDTH-1:0] aux_q,   aux_d;
        logic             done_q,  done_d;
        logic             tim_q,   tim_d;
        logic             wrap_q,  wrap_d;

        logic [WIDTH-1:0] inc_v, dec_v;
        logic             reload_evt;   // reload/wrap happening on this edge
        logic             restart;      // value re-initialised on this edge

        assign mode_c  = mode[2*ch +: 2];
        assign tempo_c = tempo[ch*WIDTH +: WIDTH];
        assign inc_v   = value_q + WIDTH'(1);
        assign dec_v   = value_q - WIDTH'(1);

        // ---- state register ----
        always_ff @(posedge clk or negedge reseta) begin
            if (!reseta) begin
                state_q <= ST_LOAD;
                value_q <= '0;
                limit_q <= '0;
                aux_q   <= '0;
                done_q  <= 1'b0;
                tim_q   <= 1'b0;
                wrap_q  <= 1'b0;
            end else begin
                state_q <= state_d;
                value_q <= value_d;
                limit_q <= limit_d;
                aux_q   <= aux_d;
                done_q  <= done_d;
                tim_q   <= tim_d;
                wrap_q  <= wrap_d;
            end
        end

        // ---- next-state logic ----
        // Priority: cfg > clr > start > tick.
        always_comb begin
            // NOTE: every signal gets a default before any branch so that no
            // path leaves it unassigned, which would infer a latch.
            state_d    = state_q;
            value_d    = value_q;
            limit_d    = limit_q;
            reload_evt = 1'b0;
            restart    = 1'b0;

            if (cfg) begin
                // Tracking the live preset while in LOAD is the same as
                // capturing it on the exit edge.
                state_d = ST_LOAD;
                value_d = init_value(mode_c, tempo_c);
                limit_d = tempo_c;
                restart = 1'b1;
            end else if (state_q == ST_LOAD || clr[ch]) begin
                // Leaving LOAD and clearing share the same capture/exit rule.
                // A tick coinciding with a clear is dropped for this channel.
                state_d = load_exit(mode_c, tempo_c, start[ch]);
                value_d = init_value(mode_c, tempo_c);
                limit_d = tempo_c;
                restart = 1'b1;
            end else begin
                case (state_q)
                    ST_RUN: begin
                        if (!start[ch]) begin
                            state_d = ST_HOLD;
                        end else if (tick) begin
                            case (mode_c)
                                MODE_UP_STOP: begin
                                    value_d = inc_v;
                                    if (inc_v == limit_q)
                                        state_d = ST_DONE;
                                end
                                MODE_DOWN_STOP: begin
                                    value_d = dec_v;
                                    if (dec_v == '0)
                                        state_d = ST_DONE;
                                end
                                MODE_DOWN_RELOAD: begin
                                    if (value_q == '0) begin
                                        value_d    = limit_q;
                                        reload_evt = 1'b1;
                                    end else begin
                                        value_d = dec_v;
                                    end
                                end
                                MODE_UP_WRAP: begin
                                    if (value_q == limit_q) begin
                                        value_d    = '0;
                                        reload_evt = 1'b1;
                                    end else begin
                                        value_d = inc_v;
                                    end
                                end
                            endcase
                        end
                    end
                    ST_HOLD: begin
                        // Ticks are ignored while holding.
                        if (start[ch])
                            state_d = ST_RUN;
                    end
                    ST_DONE: begin
                        // Frozen until clr or cfg, handled above.
                    end
                    ST_LOAD: begin
                        // Unreachable here: LOAD always exits in the branch above.
                        state_d = ST_LOAD;
                    end
                endcase
            end
        end

        // ---- output logic ----
        always_comb begin
            done_d = (state_d == ST_DONE);
            wrap_d = reload_evt;

            // The alarm only toggles while the channel stays in DONE; the edge
            // that enters DONE leaves it low, and any restart clears it.
            if (!restart && state_q == ST_DONE && state_d == ST_DONE)
                tim_d = tim_q ^ tick;
            else
                tim_d = 1'b0;

            // In configuration the display shows the preset being dialled in;
            // otherwise it follows the next value unless frozen.
            if (cfg)
                aux_d = tempo_c;
            else if (pause[ch])
                aux_d = aux_q;
            else
                aux_d = value_d;
        end

        assign aux[ch*WIDTH +: WIDTH] = aux_q;
        assign done[ch]               = done_q;
        assign tim[ch]                = tim_q;
        assign wrap[ch]               = wrap_q;
    end

endmodule

// File: doc/multi_contador.md
# multi_contador

Parametrised multi-channel stopwatch/countdown timer: NCH independent channels share one prescaler that divides `clk` down to a one-second tick. Each channel counts up or down between 0 and a per-channel limit, with four modes (including auto-reload), run/hold control, per-channel clear and a display freeze. It is the generalised successor of the single-channel counter feeding the BCD display and buzzer path.

## Interface

- `WIDTH`, 16, bits per channel value and limit
- `NCH`, 2, number of channels
- `TICK_DIV`, 25000000, `clk` cycles per tick (≥2); prescaler width is clog2(TICK_DIV)

- `clk` in 1: system clock, single clock domain
- `reseta` in 1: asynchronous, active-low reset
- `cfg` in 1: 1 = configuration mode, all channels held in LOAD
- `mode` in 2*NCH: per channel, 00 up-stop, 01 down-stop, 10 down-reload, 11 up-wrap
- `tempo` in WIDTH*NCH: per-channel limit/preset; channel i at [i*WIDTH +: WIDTH]
- `start` in NCH: level; 1 = count, 0 = hold
- `clr` in NCH: synchronous per-channel clear, sampled every cycle
- `pause` in NCH: 1 = freeze `aux` only; counting continues
- `aux` out WIDTH*NCH: displayed value per channel
- `done` out NCH: level, channel at terminal in modes 00/01
- `tim` out NCH: alarm square wave, toggles once per tick while `done`
- `wrap` out NCH: one-cycle pulse on reload/wrap in modes 10/11

## Operation

- Prescaler: counts 0..TICK_DIV-1 while `cfg`=0; `tick` is high on the cycle it equals TICK_DIV-1, then it returns to 0. It is held at 0 while `cfg`=1. `clr` does not touch it.
- Per channel registers: `value`, `limit`, state, `aux`, `done`, `tim`, `wrap`.
- Initial value: 0 for modes 00/11; `limit` for modes 01/10. Terminal: `value`==`limit` (00), `value`==0 (01).
- `limit` captures `tempo` on leaving LOAD and on `clr`; later `tempo` changes are ignored until the next capture.
- States: LOAD, RUN, HOLD, DONE.
  - Any state with `cfg`=1 → LOAD. In LOAD: `value`=initial computed from live `tempo`, `aux`=`tempo`, and `done`/`tim`/`wrap`=0.
  - LOAD with `cfg`=0 → the initial value is terminal (mode 00 with `tempo`=0, or mode 01 with `tempo`=0) ? DONE : (`start` ? RUN : HOLD).
  - RUN with `start`=0 → HOLD. HOLD with `start`=1 → RUN. HOLD ignores ticks.
  - RUN on tick:
    - 00: `value`+1; when the result equals `limit` → DONE.
    - 01: `value`-1; when the result is 0 → DONE.
    - 10: if `value`==0, load `limit` and pulse `wrap`; else `value`-1.
    - 11: if `value`==`limit`, set 0 and pulse `wrap`; else `value`+1.
  - DONE: `value` frozen, `done`=1, `tim` toggles on each tick; exits only via `clr` or `cfg`.
  - `clr` (any non-LOAD state): `limit`←`tempo`, `value`←initial, `done`/`tim`=0, next state per the LOAD-exit rule.
- Priority: `reseta` > `cfg` > `clr` > `start` > tick.
- `aux`: loaded with the next `value` on every edge where `pause`=0; holds while `pause`=1. `pause` does not affect `done`/`tim`/`wrap`.
- Arithmetic is modulo 2^WIDTH; the rules above prevent overflow/underflow.

## Timing

- Reset values: `aux`=0, `done`=0, `tim`=0, `wrap`=0, `value`=0, prescaler=0, state LOAD.
- First tick occurs TICK_DIV cycles after the first edge with `cfg`=0; subsequent ticks follow every TICK_DIV cycles.
- `value`, `aux` and `done` update on the edge that samples `tick` high, with no additional latency.
- `wrap` is high for exactly the cycle after the reload edge.
- `clr` takes effect on the next edge. If `clr` and tick coincide, `clr` wins and the tick is lost for that channel.
- Asserting `reseta` mid-operation clears all outputs immediately, without waiting for a clock edge.

## Test plan

- Reset: `reseta`=0 with random inputs → all outputs 0. Release with `cfg`=1, `tempo`=7 → `aux`=7.
- Mode 00, TICK_DIV=4, `tempo`=3, `start`=1, `cfg` 1→0 → `aux` 1,2,3 at cycles 4,8,12. `done`=1 at cycle 12. `tim` toggles at cycles 16 and 20.
- Mode 01, `tempo`=2, `pause` set at `aux`=1 → `aux` stays 1 while `done` rises at 0. Releasing `pause` → `aux`=0.
- Mode 10, `tempo`=2 → sequence 2,1,0,2 with a one-cycle `wrap` on the reload. Mode 11, `tempo`=1 on channel 1 → sequence 0,1,0 with `wrap`. Channels are independent.
- `start`=0 for 10 ticks → `value` frozen. `clr` on the same cycle as a tick at `value`=5 (mode 00, `tempo`=9) → `value`=0, no increment.
- `cfg`=1 while in DONE → `done`=`tim`=0 and `aux`=`tempo`. `reseta` pulse mid-RUN → outputs clear asynchronously.
